// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : bus_arbiter_rr                                              |
// | Purpose  : Single-bus arbiter for NUM_MASTERS masters. Round-robin or  |
// |            fixed-priority selection, one-cold active-low grants, and   |
// |            zero-bubble handover on transfer completion.                |
// | Options  : BUS_ARB_TIMEOUT_EN - when defined, builds an owned-cycle    |
// |            counter that forces release after TIMEOUT_CYC cycles and    |
// |            pulses timeout_err; when undefined timeout_err is tied 0.   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module bus_arbiter_rr #(
   parameter  int NUM_MASTERS = 4,
   parameter  int FIXED_PRIO  = 0,
   parameter  int TIMEOUT_CYC = 255,
   localparam int OW          = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                   bus_clk,
   input  logic                   bus_rstn,
   input  logic [NUM_MASTERS-1:0] m_reqn,
   input  logic                   s_asn,
   input  logic                   m_rdy,
   output logic [NUM_MASTERS-1:0] m_grntn,
   output logic [OW-1:0]          owner,
   output logic                   bus_busy,
   output logic                   timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      XFER  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grntn_q, grntn_d;
   logic [OW-1:0]          owner_q, owner_d;
   logic [OW-1:0]          ptr_q,   ptr_d;
   logic                   busy_q,  busy_d;
   logic [NUM_MASTERS-1:0] req;
   logic                   rearb;
   logic                   tmo_hit;
   logic                   win_found;
   logic [OW-1:0]          win_idx;

   // Returns {found, index}. Round-robin scans upward from start with
   // wrap; fixed priority always scans from index 0.
   function automatic logic [OW:0] pick(input logic [NUM_MASTERS-1:0] r,
                                        input logic [OW-1:0]          start);
      logic          found;
      logic [OW-1:0] idx;
      int            j;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         j = (FIXED_PRIO != 0) ? i : int'(start) + i;
         if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
         if (!found && r[j]) begin
            found = 1'b1;
            idx   = OW'(j);
         end
      end
      return {found, idx};
   endfunction

   // Next-state logic: decides when to (re)arbitrate and what to grant.
   always_comb begin
      req                  = ~m_reqn;
      {win_found, win_idx} = pick(req, ptr_q);
      state_d = state_q;
      grntn_d = grntn_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      rearb   = 1'b0;

      case (state_q)
         IDLE:  rearb = 1'b1;
         GRANT: begin
            // forced release outranks a late address strobe
            if (tmo_hit)                rearb   = 1'b1;
            else if (!s_asn)            state_d = XFER;
            else if (m_reqn[owner_q])   rearb   = 1'b1;
         end
         XFER:  if (m_rdy || tmo_hit) rearb = 1'b1;
         default: state_d = IDLE;
      endcase

      if (rearb) begin
         if (win_found) begin
            state_d = GRANT;
            grntn_d = ~({{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_idx);
            owner_d = win_idx;
            ptr_d   = (win_idx == OW'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
         end else begin
            // owner keeps the last winner while idle
            state_d = IDLE;
            grntn_d = '1;
         end
      end

      busy_d = ~&grntn_d;
   end

   // State and registered outputs; reset releases the bus immediately.
   always_ff @(posedge bus_clk or negedge bus_rstn) begin
      if (!bus_rstn) begin
         state_q <= IDLE;
         grntn_q <= '1;
         owner_q <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grntn_q <= grntn_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   assign m_grntn  = grntn_q;
   assign owner    = owner_q;
   assign bus_busy = busy_q;

`ifdef BUS_ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        tmo_q, tmo_d;

   // Counter reaching TIMEOUT_CYC-1 means this edge is the limit edge.
   assign tmo_hit = (state_q != IDLE) && (cnt_q == 16'(TIMEOUT_CYC - 1));

   // Owned-cycle counter: clears on any arbitration, counts while owned.
   always_comb begin
      cnt_d = cnt_q;
      if (rearb)                 cnt_d = '0;
      else if (state_q != IDLE)  cnt_d = cnt_q + 16'd1;
      // a normal completion on the limit edge is not an error
      tmo_d = tmo_hit && !((state_q == XFER) && m_rdy);
   end

   // Counter and error-pulse registers.
   always_ff @(posedge bus_clk or negedge bus_rstn) begin
      if (!bus_rstn) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign timeout_err = tmo_q;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_bus_arbiter_rr                                           |
// | Purpose  : Directed, table-driven bench for bus_arbiter_rr: 4-master   |
// |            round-robin, 4-master fixed priority, 16-master wrap-around.|
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_bus_arbiter_rr;

   logic bus_clk  = 1'b0;
   logic bus_rstn = 1'b1;

   always #5 bus_clk = ~bus_clk;

   // round-robin, 4 masters
   logic [3:0]  rr_reqn = 4'b1111;
   logic        rr_asn  = 1'b1;
   logic        rr_rdy  = 1'b0;
   logic [3:0]  rr_grntn;
   logic [1:0]  rr_owner;
   logic        rr_busy, rr_tmo;

   // fixed priority, 4 masters
   logic [3:0]  fx_reqn = 4'b1111;
   logic        fx_asn  = 1'b1;
   logic        fx_rdy  = 1'b0;
   logic [3:0]  fx_grntn;
   logic [1:0]  fx_owner;
   logic        fx_busy, fx_tmo;

   // round-robin, 16 masters
   logic [15:0] w_reqn = 16'hFFFF;
   logic        w_asn  = 1'b1;
   logic        w_rdy  = 1'b0;
   logic [15:0] w_grntn;
   logic [3:0]  w_owner;
   logic        w_busy, w_tmo;

   bus_arbiter_rr #(.NUM_MASTERS(4), .FIXED_PRIO(0), .TIMEOUT_CYC(8)) u_rr (
      .bus_clk(bus_clk), .bus_rstn(bus_rstn), .m_reqn(rr_reqn), .s_asn(rr_asn),
      .m_rdy(rr_rdy), .m_grntn(rr_grntn), .owner(rr_owner), .bus_busy(rr_busy),
      .timeout_err(rr_tmo));

   bus_arbiter_rr #(.NUM_MASTERS(4), .FIXED_PRIO(1), .TIMEOUT_CYC(255)) u_fx (
      .bus_clk(bus_clk), .bus_rstn(bus_rstn), .m_reqn(fx_reqn), .s_asn(fx_asn),
      .m_rdy(fx_rdy), .m_grntn(fx_grntn), .owner(fx_owner), .bus_busy(fx_busy),
      .timeout_err(fx_tmo));

   bus_arbiter_rr #(.NUM_MASTERS(16), .FIXED_PRIO(0), .TIMEOUT_CYC(255)) u_w (
      .bus_clk(bus_clk), .bus_rstn(bus_rstn), .m_reqn(w_reqn), .s_asn(w_asn),
      .m_rdy(w_rdy), .m_grntn(w_grntn), .owner(w_owner), .bus_busy(w_busy),
      .timeout_err(w_tmo));

   typedef struct {
      logic [3:0] reqn;
      logic       asn;
      logic       rdy;
      logic [3:0] grntn;
      logic [1:0] own;
      logic       busy;
   } vec_t;

   vec_t tbl[25];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step_fx(input logic [3:0] reqn, input logic asn, input logic rdy,
                          input logic [3:0] eg, input logic [1:0] eo);
      fx_reqn = reqn; fx_asn = asn; fx_rdy = rdy;
      @(posedge bus_clk); #1;
      chk("fx_grntn", 32'(fx_grntn), 32'(eg));
      chk("fx_owner", 32'(fx_owner), 32'(eo));
      @(negedge bus_clk);
   endtask

   task automatic step_w(input logic [15:0] reqn, input logic asn, input logic rdy,
                         input logic [15:0] eg, input logic [3:0] eo);
      w_reqn = reqn; w_asn = asn; w_rdy = rdy;
      @(posedge bus_clk); #1;
      chk("w16_grntn", 32'(w_grntn), 32'(eg));
      chk("w16_owner", 32'(w_owner), 32'(eo));
      chk("w16_busy",  32'(w_busy),  32'(eg != 16'hFFFF));
      @(negedge bus_clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] eg;
      logic       et;

      //            reqn     asn   rdy   grntn    own   busy
      // round-robin chain, zero-bubble handovers 0,1,2,3,0
      tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1};
      tbl[1]  = '{4'b0000, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1};
      tbl[2]  = '{4'b0000, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1};
      tbl[3]  = '{4'b0000, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b1};
      tbl[4]  = '{4'b0000, 1'b0, 1'b0, 4'b1101, 2'd1, 1'b1};
      tbl[5]  = '{4'b0000, 1'b0, 1'b0, 4'b1101, 2'd1, 1'b1};
      tbl[6]  = '{4'b0000, 1'b0, 1'b1, 4'b1011, 2'd2, 1'b1};
      tbl[7]  = '{4'b0000, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1};
      tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1};
      tbl[9]  = '{4'b0000, 1'b0, 1'b1, 4'b0111, 2'd3, 1'b1};
      tbl[10] = '{4'b0000, 1'b0, 1'b0, 4'b0111, 2'd3, 1'b1};
      tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0111, 2'd3, 1'b1};
      tbl[12] = '{4'b0000, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b1};
      // XFER holds with requests gone, completion with no requests -> idle
      tbl[13] = '{4'b1111, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1};
      tbl[14] = '{4'b1111, 1'b0, 1'b1, 4'b1111, 2'd0, 1'b0};
      // master 2 granted (pointer 1), withdraws before strobe -> released
      tbl[15] = '{4'b1011, 1'b1, 1'b0, 4'b1011, 2'd2, 1'b1};
      tbl[16] = '{4'b1111, 1'b1, 1'b0, 4'b1111, 2'd2, 1'b0};
      tbl[17] = '{4'b1111, 1'b1, 1'b0, 4'b1111, 2'd2, 1'b0};
      // no preemption: later requests wait for completion
      tbl[18] = '{4'b1110, 1'b1, 1'b0, 4'b1110, 2'd0, 1'b1};
      tbl[19] = '{4'b1100, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1};
      tbl[20] = '{4'b1000, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1};
      tbl[21] = '{4'b1000, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b1};
      // sole requester wins again after its own completion
      tbl[22] = '{4'b1101, 1'b0, 1'b0, 4'b1101, 2'd1, 1'b1};
      tbl[23] = '{4'b1101, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b1};
      tbl[24] = '{4'b1111, 1'b1, 1'b0, 4'b1111, 2'd1, 1'b0};

      // reset state
      #3 bus_rstn = 1'b0;
      #1;
      chk("rst_grntn", 32'(rr_grntn), 32'hF);
      chk("rst_owner", 32'(rr_owner), 32'h0);
      chk("rst_busy",  32'(rr_busy),  32'h0);
      chk("rst_tmo",   32'(rr_tmo),   32'h0);
      repeat (2) @(negedge bus_clk);
      bus_rstn = 1'b1;

      for (int i = 0; i < 25; i++) begin
         rr_reqn = tbl[i].reqn; rr_asn = tbl[i].asn; rr_rdy = tbl[i].rdy;
         @(posedge bus_clk); #1;
         chk($sformatf("tbl%0d_grntn", i), 32'(rr_grntn), 32'(tbl[i].grntn));
         chk($sformatf("tbl%0d_owner", i), 32'(rr_owner), 32'(tbl[i].own));
         chk($sformatf("tbl%0d_busy",  i), 32'(rr_busy),  32'(tbl[i].busy));
         chk($sformatf("tbl%0d_tmo",   i), 32'(rr_tmo),   32'h0);
         @(negedge bus_clk);
      end

      // asynchronous reset in the middle of a transfer by master 3
      rr_reqn = 4'b0111; rr_asn = 1'b0; rr_rdy = 1'b0;
      @(posedge bus_clk); #1;
      chk("pre_rst_grntn", 32'(rr_grntn), 32'h7);
      @(negedge bus_clk);
      @(posedge bus_clk); #1;
      chk("pre_rst_xfer", 32'(rr_grntn), 32'h7);
      @(negedge bus_clk);
      bus_rstn = 1'b0;
      #1;
      chk("midrst_grntn", 32'(rr_grntn), 32'hF);
      chk("midrst_owner", 32'(rr_owner), 32'h0);
      chk("midrst_busy",  32'(rr_busy),  32'h0);
      rr_reqn = 4'b0011;
      @(negedge bus_clk);
      bus_rstn = 1'b1;
      @(posedge bus_clk); #1;
      chk("postrst_grntn", 32'(rr_grntn), 32'hB);
      chk("postrst_owner", 32'(rr_owner), 32'h2);

      // stuck m_rdy: forced release 8 cycles after the grant when enabled
      for (int k = 1; k <= 9; k++) begin
         @(negedge bus_clk);
         @(posedge bus_clk); #1;
`ifdef BUS_ARB_TIMEOUT_EN
         eg = (k >= 8) ? 4'b0111 : 4'b1011;
         et = (k == 8);
`else
         eg = 4'b1011;
         et = 1'b0;
`endif
         chk($sformatf("tmo%0d_grntn", k), 32'(rr_grntn), 32'(eg));
         chk($sformatf("tmo%0d_err", k),   32'(rr_tmo),   32'(et));
      end
      @(negedge bus_clk);
      rr_reqn = 4'b1111; rr_asn = 1'b1;

      // fixed priority: master 1 beats master 3 every time
      step_fx(4'b0101, 1'b0, 1'b0, 4'b1101, 2'd1);
      step_fx(4'b0101, 1'b0, 1'b0, 4'b1101, 2'd1);
      step_fx(4'b0101, 1'b0, 1'b1, 4'b1101, 2'd1);
      step_fx(4'b0101, 1'b0, 1'b0, 4'b1101, 2'd1);
      step_fx(4'b0101, 1'b0, 1'b1, 4'b1101, 2'd1);
      step_fx(4'b1111, 1'b1, 1'b0, 4'b1111, 2'd1);
      chk("fx_tmo", 32'(fx_tmo), 32'h0);

      // 16 masters: park pointer at 15, then 15 wins and wraps to 0
      step_w(16'hBFFF, 1'b1, 1'b0, 16'hBFFF, 4'd14);
      step_w(16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 4'd14);
      step_w(16'h7FFE, 1'b1, 1'b0, 16'h7FFF, 4'd15);
      step_w(16'h7FFE, 1'b0, 1'b0, 16'h7FFF, 4'd15);
      step_w(16'h7FFE, 1'b0, 1'b1, 16'hFFFE, 4'd0);
      chk("w16_tmo", 32'(w_tmo), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of masters (legal 2..16).
REQ-002 SHALL have parameter FIXED_PRIO, default 0, arbitration mode: 0 = round-robin, 1 = fixed (lowest index wins).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, owned-cycle limit before forced release (legal 2..65535).
REQ-004 SHALL have port bus_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port bus_rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port m_reqn, input, NUM_MASTERS, bit i low = master i requests the bus.
REQ-007 SHALL have port s_asn, input, 1, muxed active-low address strobe of the current owner.
REQ-008 SHALL have port m_rdy, input, 1, muxed slave ready; high = transfer complete.
REQ-009 SHALL have port m_grntn, output, NUM_MASTERS, one-cold grant; bit i low = master i owns the bus.
REQ-010 SHALL have port owner, output, max(1,$clog2(NUM_MASTERS)), index of the granted master, mux select for master/slave muxes.
REQ-011 SHALL have port bus_busy, output, 1, high while any grant is asserted.
REQ-012 SHALL have port timeout_err, output, 1, one-cycle pulse on forced release.

Function
REQ-013 SHALL implement states IDLE, GRANT, XFER; all outputs registered.
REQ-014 IDLE: on a sampled edge with any m_reqn bit low, SHALL select a winner, assert its m_grntn bit, and enter GRANT; grant is visible 1 cycle after the request is sampled.
REQ-015 GRANT: s_asn sampled low -> XFER; owner's m_reqn sampled high with s_asn high -> drop grant, re-arbitrate as in REQ-017.
REQ-016 XFER: grant SHALL be held regardless of m_reqn until m_rdy is sampled high.
REQ-017 On completion (m_rdy high in XFER), SHALL re-arbitrate on that edge among current requests: new winner granted on the same edge (zero-bubble handover), state GRANT; with no requests, all grants high, state IDLE.
REQ-018 Round-robin: search SHALL start at pointer, wrap from NUM_MASTERS-1 to 0; pointer = winner+1 mod NUM_MASTERS on every grant; previous owner wins again only if it is the sole requester.
REQ-019 Fixed: lowest-index requesting master SHALL win; pointer unused.
REQ-020 m_grntn SHALL never have more than one bit low; owner SHALL hold the last winner when idle.
REQ-021 bus_busy SHALL equal ~&m_grntn.
REQ-022 Requests arriving in GRANT or XFER SHALL wait; no preemption.

Reset
REQ-023 bus_rstn low SHALL immediately force m_grntn all-ones, owner 0, bus_busy 0, timeout_err 0, pointer 0, counter 0, state IDLE, including mid-transfer.
REQ-024 The first arbitration SHALL occur on the first rising edge after bus_rstn deasserts.

Configuration
REQ-025 Macro BUS_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on every grant and increment each cycle in GRANT/XFER; when it reaches TIMEOUT_CYC without completion, timeout_err SHALL pulse for 1 cycle and the edge SHALL be treated as completion (REQ-017).
REQ-026 Macro BUS_ARB_TIMEOUT_EN undefined: no counter SHALL be built, timeout_err SHALL be tied 0, and ownership is unbounded.

Verification
REQ-027 NUM_MASTERS=4, RR: m_reqn=4'b0000 held, each transfer completes 3 cycles after grant -> grant order 0,1,2,3,0 with no idle cycle between grants.
REQ-028 FIXED_PRIO=1: m_reqn=4'b0101 -> master1 granted; after completion, with master1 still requesting -> master1 again; master3 never granted.
REQ-029 Master 2 requests, is granted, raises m_reqn before s_asn -> m_grntn=4'b1111 next cycle, state IDLE.
REQ-030 BUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, m_rdy stuck 0 -> timeout_err pulses 8 cycles after grant, grant moves to next requester on the same edge.
REQ-031 bus_rstn low during XFER -> m_grntn=all-ones before the next clock edge; after release, lowest requester granted (pointer 0).
REQ-032 NUM_MASTERS=16, RR, only master 15 and master 0 request, pointer at 15 -> master 15 then 0 (wrap-around).
